// File: rtl/i2c_rom_seq_engine_pkg.sv
// Types shared by the ROM-driven I2C/SCCB init sequencer and the I2C master it feeds.
package i2c_rom_seq_engine_pkg;

    typedef struct packed {
        logic       we;
        logic       sccb_mode;
        logic [6:0] addr_slave;
        logic [7:0] addr_reg;
        logic [7:0] burst_num;
    } t_i2c_cmd;

    typedef enum logic [3:0] {
        OP_WRITE = 4'h0,
        OP_DELAY = 4'h1,
        OP_POLL  = 4'h2,
        OP_END   = 4'hF
    } t_seq_opcode;

    // Opcode kept as raw bits so illegal encodings survive decode and can be flagged.
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rsvd;
        logic [7:0] reg_addr;
        logic [7:0] data;
        logic [7:0] mask;
    } t_seq_word;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_NACK   = 2'd1,
        ERR_POLL   = 2'd2,
        ERR_OPCODE = 2'd3
    } t_seq_err;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_REQ,
        ST_WAIT,
        ST_DELAY,
        ST_ERROR
    } t_seq_state;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/i2c_rom_seq_engine.sv
// Walks a sync init ROM and issues WRITE / DELAY / POLL commands to the shared I2C master,
// with NACK retry, poll timeout and sticky error reporting.
//
// state  | meaning
// IDLE   | waiting for i_start (or first run after reset when auto-start is enabled)
// FETCH  | o_addr presented, ROM word arrives next cycle
// DECODE | word on i_data: dispatch on opcode, clear retry/poll counters
// REQ    | o_cmd_valid held until the master accepts
// WAIT   | waiting for the master's response pulse
// DELAY  | down-counting timer, leaves at terminal count 0
// ERROR  | one cycle: publish error code/address, then IDLE
module i2c_rom_seq_engine
    import i2c_rom_seq_engine_pkg::*;
#(
    parameter bit         p_sccb_mode      = 1'b1,
    parameter logic [6:0] p_slave_addr     = 7'h21,
    parameter int         p_rom_addr_width = 8,
    parameter int         p_delay_unit     = 1000,
    parameter int         p_max_retries    = 3,
    parameter int         p_poll_max       = 255,
    parameter bit         p_auto_start     = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic [p_rom_addr_width-1:0] o_addr,
    input  logic [31:0]                 i_data,
    output logic                        o_cmd_valid,
    output t_i2c_cmd                    o_cmd_data,
    output logic [7:0]                  o_wr_data,
    input  logic                        i_cmd_ready,
    input  logic                        i_rsp_valid,
    input  logic                        i_rsp_nack,
    input  logic [7:0]                  i_rsp_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic [1:0]                  o_err_code,
    output logic [p_rom_addr_width-1:0] o_err_addr
);

    localparam int AW       = p_rom_addr_width;
    localparam int TIMER_W  = 24 + $clog2(p_delay_unit);
    localparam int RETRY_W  = clog2_min1(p_max_retries + 1);
    localparam int POLL_W   = clog2_min1(p_poll_max + 1);

    typedef logic [TIMER_W-1:0] t_timer;

    localparam t_timer              DELAY_UNIT  = t_timer'(p_delay_unit);
    localparam logic [RETRY_W-1:0]  MAX_RETRIES = RETRY_W'(p_max_retries);
    localparam logic [POLL_W-1:0]   POLL_MAX    = POLL_W'(p_poll_max);

    typedef struct packed {
        t_seq_state          state;
        logic [AW-1:0]       addr;
        logic                cmd_valid;
        t_i2c_cmd            cmd;
        logic [7:0]          wr_data;
        logic [7:0]          poll_expect;
        logic [7:0]          poll_mask;
        logic                done;
        logic                error;
        t_seq_err            err_code;
        t_seq_err            err_pend;
        logic [AW-1:0]       err_addr;
        logic                init;
        t_timer              timer;
        logic [RETRY_W-1:0]  retries;
        logic [POLL_W-1:0]   polls;
    } t_regs;

    t_regs     r;
    t_regs     nx;
    t_seq_word word_in;
    t_timer    delay_load;
    logic      unused_rsvd;

    assign word_in     = t_seq_word'(i_data);
    assign delay_load  = t_timer'(i_data[23:0]) * DELAY_UNIT - t_timer'(1);
    assign unused_rsvd = ^word_in.rsvd;

    always_comb begin
        nx      = r;
        nx.done = 1'b0;
        case (r.state)
            ST_IDLE: begin
                if (i_start || (p_auto_start && !r.init)) begin
                    nx.addr     = '0;
                    nx.error    = 1'b0;
                    nx.err_code = ERR_NONE;
                    nx.state    = ST_FETCH;
                end
            end
            ST_FETCH: nx.state = ST_DECODE;
            ST_DECODE: begin
                // Only the poll compare needs the word after decode; the command fields live in cmd.
                nx.poll_expect = word_in.data;
                nx.poll_mask   = word_in.mask;
                nx.retries     = '0;
                nx.polls       = '0;
                nx.cmd         = '{we:         (word_in.opcode == OP_WRITE),
                                   sccb_mode:  p_sccb_mode,
                                   addr_slave: p_slave_addr,
                                   addr_reg:   word_in.reg_addr,
                                   burst_num:  '0};
                nx.wr_data     = word_in.data;
                case (word_in.opcode)
                    OP_WRITE, OP_POLL: begin
                        nx.cmd_valid = 1'b1;
                        nx.state     = ST_REQ;
                    end
                    OP_DELAY: begin
                        if (i_data[23:0] == 24'd0) begin
                            nx.addr  = r.addr + 1'b1;
                            nx.state = ST_FETCH;
                        end else begin
                            nx.timer = delay_load;
                            nx.state = ST_DELAY;
                        end
                    end
                    OP_END: begin
                        nx.done  = 1'b1;
                        nx.init  = 1'b1;
                        nx.addr  = '0;
                        nx.state = ST_IDLE;
                    end
                    default: begin
                        nx.err_pend = ERR_OPCODE;
                        nx.state    = ST_ERROR;
                    end
                endcase
            end
            ST_REQ: begin
                if (i_cmd_ready) begin
                    nx.cmd_valid = 1'b0;
                    nx.state     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_rsp_valid) begin
                    if (i_rsp_nack) begin
                        if (r.retries < MAX_RETRIES) begin
                            nx.retries   = r.retries + 1'b1;
                            nx.cmd_valid = 1'b1;
                            nx.state     = ST_REQ;
                        end else begin
                            nx.err_pend = ERR_NACK;
                            nx.state    = ST_ERROR;
                        end
                    end else if (r.cmd.we ||
                                 (((i_rsp_data ^ r.poll_expect) & r.poll_mask) == 8'h00)) begin
                        nx.addr  = r.addr + 1'b1;
                        nx.state = ST_FETCH;
                    end else begin
                        nx.polls = r.polls + 1'b1;
                        if (nx.polls == POLL_MAX) begin
                            nx.err_pend = ERR_POLL;
                            nx.state    = ST_ERROR;
                        end else begin
                            nx.cmd_valid = 1'b1;
                            nx.state     = ST_REQ;
                        end
                    end
                end
            end
            ST_DELAY: begin
                if (r.timer == '0) begin
                    nx.addr  = r.addr + 1'b1;
                    nx.state = ST_FETCH;
                end else begin
                    nx.timer = r.timer - 1'b1;
                end
            end
            ST_ERROR: begin
                nx.error    = 1'b1;
                nx.err_code = r.err_pend;
                nx.err_addr = r.addr;
                nx.init     = 1'b1;
                nx.state    = ST_IDLE;
            end
            default: nx.state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r <= '0;
        end else begin
            r <= nx;
        end
    end

    assign o_addr      = r.addr;
    assign o_cmd_valid = r.cmd_valid;
    assign o_cmd_data  = r.cmd;
    assign o_wr_data   = r.wr_data;
    assign o_busy      = (r.state != ST_IDLE);
    assign o_done      = r.done;
    assign o_error     = r.error;
    assign o_err_code  = r.err_code;
    assign o_err_addr  = r.err_addr;

endmodule

// File: doc/i2c_rom_seq_engine.md
Name: i2c_rom_seq_engine

Overview:
Successor to the single-opcode ROM command parser. It walks a sync ROM of 32-bit opcode words and issues I2C/SCCB commands to the shared I2C master. Supported opcodes are register write, programmable delay, poll-until-match read, and end. It adds NACK retry, poll timeout, and error reporting. It sits between the camera/sensor init ROM and the I2C master, and runs once after reset or on each i_start.

Parameters:
p_sccb_mode, 1, copied into every issued command's sccb_mode field
p_slave_addr, 'h21, 7-bit slave address placed in every command
p_rom_addr_width, 8, ROM address width; max 2**p_rom_addr_width entries
p_delay_unit, 1000, i_clk cycles per DELAY tick
p_max_retries, 3, re-issues of a NACKed command before error
p_poll_max, 255, maximum POLL read attempts before error
p_auto_start, 1, run the sequence once after reset without i_start

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_start  in  1  pulse; restart sequence from address 0 (ignored unless IDLE)
o_addr  out  p_rom_addr_width  ROM address (registered)
i_data  in  32  ROM word, valid 1 cycle after o_addr changes
o_cmd_valid  out  1  command request
o_cmd_data  out  t_i2c_cmd  we, sccb_mode, addr_slave, addr_reg, burst_num='0
o_wr_data  out  8  write byte
i_cmd_ready  in  1  master idle/accepting
i_rsp_valid  in  1  1-cycle pulse: issued command finished
i_rsp_nack  in  1  qualifies i_rsp_valid: slave NACKed
i_rsp_data  in  8  read byte, qualifies i_rsp_valid on reads
o_busy  out  1  high in any state except IDLE
o_done  out  1  1-cycle pulse on successful END
o_error  out  1  sticky until next start; set on failure
o_err_code  out  2  1=NACK exhausted, 2=POLL timeout, 3=illegal opcode
o_err_addr  out  p_rom_addr_width  ROM address of the failing word

Behaviour:
- Reset is i_rst, synchronous, active-high, on clock i_clk.
- Reset values: state IDLE; o_addr=0; o_cmd_valid=0; o_done=0; o_error=0; o_err_code=0; o_err_addr=0; internal init flag=0.
- ROM word fields: [31:28] opcode; [23:16] reg; [15:8] data/expect; [7:0] mask; DELAY count is [23:0].
- Opcodes: 0 WRITE; 1 DELAY; 2 POLL; 0xF END; all others are illegal.
- IDLE: if i_start, or (p_auto_start and init=0): set o_addr=0, clear o_error and o_err_code, go to FETCH.
- FETCH: wait 1 cycle for ROM latency, go to DECODE.
- DECODE: latch i_data. Clear retry and poll counters.
  - WRITE or POLL -> REQ.
  - DELAY: load timer = count*p_delay_unit-1, go to DELAY. A count of 0 means no wait: o_addr++ and go to FETCH.
  - END: pulse o_done, set init=1, set o_addr=0, go to IDLE.
  - Illegal opcode -> ERROR with code 3.
- REQ:
  - o_cmd_valid=1 while i_cmd_ready=0. Transfer happens on the cycle o_cmd_valid & i_cmd_ready, then go to WAIT.
  - o_cmd_data.we = 1 for WRITE, 0 for POLL.
  - o_cmd_data and o_wr_data are stable from REQ entry until the response arrives.
- WAIT: act on i_rsp_valid.
  - Response with nack=1:
    - If retries < p_max_retries: retries++, go to REQ.
    - Otherwise: ERROR with code 1.
  - WRITE with ack: o_addr++, go to FETCH.
  - POLL with ack:
    - If (i_rsp_data & mask) == (expect & mask): o_addr++, go to FETCH.
    - Otherwise: polls++. If polls == p_poll_max, ERROR with code 2; else go to REQ.
  - A POLL NACK consumes a retry, not a poll attempt.
- DELAY: the timer decrements each cycle. At 0: o_addr++, go to FETCH. Total DELAY state cycles = count*p_delay_unit.
- ERROR: for one cycle, set o_error=1, o_err_code, o_err_addr=o_addr; set init=1 so the engine does not auto-restart; go to IDLE.
- o_addr wrap-around: incrementing past the max address wraps to 0. A ROM must terminate with END.
- i_start outside IDLE is ignored. i_rsp_valid outside WAIT is ignored.
- i_rst mid-transaction aborts immediately. o_cmd_valid drops on the next edge. The master is reset by the same i_rst.
- Timer and counter widths: timer is $clog2(2**24*p_delay_unit) bits; retry counter is $clog2(p_max_retries+1) bits; poll counter is $clog2(p_poll_max+1) bits.

Decomposition:
- package_i2c gets: t_seq_opcode enum (OP_WRITE, OP_DELAY, OP_POLL, OP_END); t_seq_word packed struct for the ROM word fields; t_seq_err enum. The existing t_i2c_cmd struct is reused.
- Single module with a registered state struct plus a next-state always_comb.
- No sub-module, except an optional i2c_seq_rom (sync ROM, $readmemh) for the bench and top level.

Test Plan:
- ROM {WRITE 0x12=0x80, WRITE 0x11=0x01, END}, master always acks -> exactly 2 commands issued with addr_reg 0x12/0x11 and wr_data 0x80/0x01, we=1; o_done pulses once; o_addr returns to 0.
- DELAY count=3, p_delay_unit=4 -> exactly 12 cycles in DELAY; the next command is issued after that.
- WRITE NACKed twice then acked, p_max_retries=3 -> 3 requests with identical cmd data; no error; sequence completes.
- WRITE always NACKed at ROM address 5 -> 4 requests; o_error=1, o_err_code=1, o_err_addr=5; no o_done.
- POLL reg 0x0A expect 0x76 mask 0xF0; responses 0x00, 0x00, 0x7F -> 3 reads with we=0, then advance. Same POLL with p_poll_max=2 -> o_err_code=2.
- Opcode 0x5 -> o_err_code=3. Also: i_rst asserted mid-WAIT, then released -> auto-start reruns from address 0.
